// File: rtl/race_engine_multi_pkg.sv
// race_pkg: shared types and constants for the lane-racing game-state engine.
//   race_state_t : top-level engine states
//   SPEED        : opponent fall speed per level (pixels/frame), index = level
//   LFSR_SEED/LFSR_TAPS : 16-bit Fibonacci LFSR, taps 16/14/13/11
//   lane_x()     : left edge x of lane k
package race_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_RUN,
    S_CRASH
  } race_state_t;

  // SPEED[0] = 6, SPEED[1] = 8, SPEED[2] = 11, SPEED[3] = 14
  localparam logic [3:0][3:0] SPEED = {4'd14, 4'd11, 4'd8, 4'd6};

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Tap mask on q[15], q[13], q[12], q[10]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [9:0] lane_x(input int unsigned x0,
                                        input int unsigned pitch,
                                        input int unsigned k);
    return 10'(x0 + k * pitch);
  endfunction

endpackage

// File: rtl/race_engine_multi_lfsr.sv
// race_lfsr16: free-running 16-bit Fibonacci LFSR used for lane selection.
//   clk   in  1  : system clock
//   rst_n in  1  : asynchronous active-low reset (loads the seed)
//   q     out 16 : current LFSR state, advances every clock, never zero
module race_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);
  import race_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= LFSR_SEED;
    else        q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/race_engine_multi.sv
// race_engine_multi: per-frame game-state engine for the lane-racing demo.
// One player car and N_OPP opponent slots, updated by a sequential sweep
// (N_OPP + 2 cycles) started by frame_tick while running.
//   clk        in  1          : system clock
//   reset      in  1          : asynchronous active-low reset
//   frame_tick in  1          : one-cycle pulse per video frame
//   start      in  1          : start/restart request (IDLE or CRASH only)
//   control    in  2          : 2'b10 right, 2'b01 left, others hold
//   player_x   out 10         : player left edge
//   opp_x      out 10*N_OPP   : slot i at [10i+9:10i]
//   opp_y      out 9*N_OPP    : slot i at [9i+8:9i]
//   opp_active out N_OPP      : slot valid
//   score      out SCORE_W    : opponents passed (saturating)
//   level      out 2          : min(score / LEVEL_PTS, 3)
//   crash      out 1          : high while in CRASH
//   busy       out 1          : sweep in progress
module race_engine_multi #(
  parameter int unsigned N_OPP        = 3,
  parameter int unsigned LANES        = 3,
  parameter int unsigned LANE_X0      = 178,
  parameter int unsigned LANE_PITCH   = 106,
  parameter int unsigned SPR_W        = 72,
  parameter int unsigned SPR_H        = 84,
  parameter int unsigned SCR_H        = 480,
  parameter int unsigned PLAYER_Y     = 380,
  parameter int unsigned X_MIN        = 163,
  parameter int unsigned X_MAX        = 478,
  parameter int unsigned STEP_X       = 5,
  parameter int unsigned SPAWN_FRAMES = 40,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned LEVEL_PTS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic [1:0]           control,
  output logic [9:0]           player_x,
  output logic [10*N_OPP-1:0]  opp_x,
  output logic [9*N_OPP-1:0]   opp_y,
  output logic [N_OPP-1:0]     opp_active,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           level,
  output logic                 crash,
  output logic                 busy
);
  import race_pkg::*;

  localparam int unsigned CNT_W  = $clog2(N_OPP + 2);
  localparam int unsigned SLOT_W = (N_OPP > 1) ? $clog2(N_OPP) : 1;
  localparam int unsigned SPC_W  = (SPAWN_FRAMES > 0) ? $clog2(SPAWN_FRAMES + 1) : 1;
  localparam logic [9:0]  PX_INIT = lane_x(LANE_X0, LANE_PITCH, LANES / 2);

  race_state_t        state;
  logic [CNT_W-1:0]   cnt;
  logic [SPC_W-1:0]   spawn_cnt;
  logic               spawned;
  logic               hit;
  logic [15:0]        lfsr;

  logic [9:0]         slot_x   [N_OPP];
  logic [8:0]         slot_y   [N_OPP];
  logic               slot_act [N_OPP];

  race_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .q     (lfsr)
  );

  // Shared slot datapath: the slot addressed by the sweep counter.
  logic [SLOT_W-1:0]  slot_idx;
  logic [9:0]         cur_x, nxt_x;
  logic [8:0]         cur_y, nxt_y;
  logic               cur_act, nxt_act;
  logic [3:0]         spd;
  logic [9:0]         y_sum;
  int unsigned        lane_k;
  logic               retire, spawn, slot_hit;
  logic signed [10:0] dx;
  logic [10:0]        adx;
  logic               right_ok, left_ok;
  logic [SCORE_W-1:0] score_inc, lvl_q;
  logic [1:0]         level_nxt;

  always_comb begin
    slot_idx = SLOT_W'(cnt - CNT_W'(1));
    cur_x    = slot_x[slot_idx];
    cur_y    = slot_y[slot_idx];
    cur_act  = slot_act[slot_idx];
    spd      = SPEED[level];
    // 10-bit sum so a y near the bottom cannot wrap past SCR_H
    y_sum    = {1'b0, cur_y} + {6'd0, spd};
    lane_k   = 32'(lfsr) % LANES;

    nxt_x   = cur_x;
    nxt_y   = cur_y;
    nxt_act = cur_act;
    retire  = 1'b0;
    spawn   = 1'b0;
    if (cur_act) begin
      if (y_sum >= 10'(SCR_H)) begin
        nxt_act = 1'b0;
        nxt_y   = '0;
        retire  = 1'b1;
      end else begin
        nxt_y = y_sum[8:0];
      end
    end else if (spawn_cnt == '0 && !spawned) begin
      nxt_act = 1'b1;
      nxt_y   = '0;
      nxt_x   = lane_x(LANE_X0, LANE_PITCH, lane_k);
      spawn   = 1'b1;
    end

    dx  = $signed({1'b0, nxt_x}) - $signed({1'b0, player_x});
    adx = dx[10] ? (~dx + 11'd1) : dx;
    slot_hit = nxt_act
            && (({1'b0, nxt_y} + 10'(SPR_H)) > 10'(PLAYER_Y))
            && ({1'b0, nxt_y} < 10'(PLAYER_Y + SPR_H))
            && (adx < 11'(SPR_W));

    right_ok  = (11'(player_x) + 11'(STEP_X + SPR_W)) <= 11'(X_MAX);
    left_ok   = player_x >= 10'(X_MIN + STEP_X);

    score_inc = (score == '1) ? score : score + SCORE_W'(1);
    lvl_q     = score / SCORE_W'(LEVEL_PTS);
    level_nxt = (lvl_q >= SCORE_W'(3)) ? 2'd3 : lvl_q[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      spawn_cnt <= '0;
      spawned   <= 1'b0;
      hit       <= 1'b0;
      player_x  <= PX_INIT;
      score     <= '0;
      level     <= '0;
      crash     <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < N_OPP; i++) begin
        slot_x[i]   <= '0;
        slot_y[i]   <= '0;
        slot_act[i] <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE, S_CRASH: begin
          if (start) begin
            state     <= S_RUN;
            spawn_cnt <= '0;
            player_x  <= PX_INIT;
            score     <= '0;
            level     <= '0;
            crash     <= 1'b0;
            for (int unsigned i = 0; i < N_OPP; i++) begin
              slot_x[i]   <= '0;
              slot_y[i]   <= '0;
              slot_act[i] <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (frame_tick) begin
            state   <= S_SWEEP;
            cnt     <= '0;
            busy    <= 1'b1;
            spawned <= 1'b0;
            hit     <= 1'b0;
          end
        end
        S_SWEEP: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == '0) begin
            if (control == 2'b10 && right_ok)      player_x <= player_x + 10'(STEP_X);
            else if (control == 2'b01 && left_ok) player_x <= player_x - 10'(STEP_X);
          end else if (cnt <= CNT_W'(N_OPP)) begin
            slot_x[slot_idx]   <= nxt_x;
            slot_y[slot_idx]   <= nxt_y;
            slot_act[slot_idx] <= nxt_act;
            if (retire) score <= score_inc;
            if (spawn) begin
              spawned   <= 1'b1;
              spawn_cnt <= SPC_W'(SPAWN_FRAMES);
            end
            if (slot_hit) hit <= 1'b1;
          end else begin
            if (spawn_cnt != '0) spawn_cnt <= spawn_cnt - SPC_W'(1);
            level <= level_nxt;
            busy  <= 1'b0;
            if (hit) begin
              state <= S_CRASH;
              crash <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_OPP; g++) begin : g_pack
    assign opp_x[10*g +: 10] = slot_x[g];
    assign opp_y[9*g +: 9]   = slot_y[g];
    assign opp_active[g]     = slot_act[g];
  end

endmodule

// File: tb/tb_race_engine_multi.sv
// Self-checking bench for race_engine_multi: two instances (default, and
// N_OPP=5 / SPAWN_FRAMES=1) share stimulus; a frame-level reference model
// predicts every output after each frame.
module tb_race_engine_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, frame_tick, start;
  logic [1:0] control;

  logic [9:0]  px0, px1;
  logic [29:0] ox0;
  logic [49:0] ox1;
  logic [26:0] oy0;
  logic [44:0] oy1;
  logic [2:0]  oa0;
  logic [4:0]  oa1;
  logic [15:0] sc0, sc1;
  logic [1:0]  lv0, lv1;
  logic        cr0, cr1, bz0, bz1;

  race_engine_multi dut0 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .control(control), .player_x(px0), .opp_x(ox0), .opp_y(oy0),
    .opp_active(oa0), .score(sc0), .level(lv0), .crash(cr0), .busy(bz0)
  );

  race_engine_multi #(.N_OPP(5), .SPAWN_FRAMES(1)) dut1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .control(control), .player_x(px1), .opp_x(ox1), .opp_y(oy1),
    .opp_active(oa1), .score(sc1), .level(lv1), .crash(cr1), .busy(bz1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- LFSR reference (definition: shift left, feed back taps) ----
  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] lref;
  always @(posedge clk or negedge reset) begin
    if (!reset) lref <= 16'hACE1;
    else        lref <= lstep(lref);
  end

  // ---------------- frame-level reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_CRASH = 2;
  int m_st[2], m_px[2], m_score[2], m_lv[2], m_cnt[2];
  int m_x[2][8], m_y[2][8];
  bit m_act[2][8];
  int cur_lane = 1;

  function automatic int nopp(input int k);
    return (k == 0) ? 3 : 5;
  endfunction

  function automatic int spf(input int k);
    return (k == 0) ? 40 : 1;
  endfunction

  task automatic model_clear(input int k, input int st);
    m_st[k] = st; m_px[k] = 284; m_score[k] = 0; m_lv[k] = 0; m_cnt[k] = 0;
    for (int i = 0; i < 8; i++) begin
      m_x[k][i] = 0; m_y[k][i] = 0; m_act[k][i] = 1'b0;
    end
  endtask

  task automatic model_tick(input int k, input logic [15:0] l0, input logic [1:0] ctl);
    logic [15:0] lf;
    int spd, dx;
    bit sp, hit;
    if (m_st[k] != M_RUN) return;
    if (ctl == 2'b10 && m_px[k] + 5 + 72 <= 478)     m_px[k] += 5;
    else if (ctl == 2'b01 && m_px[k] - 5 >= 163)     m_px[k] -= 5;
    spd = (m_lv[k] == 0) ? 6 : (m_lv[k] == 1) ? 8 : (m_lv[k] == 2) ? 11 : 14;
    lf  = lstep(l0);
    sp  = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < nopp(k); i++) begin
      lf = lstep(lf);
      if (m_act[k][i]) begin
        if (m_y[k][i] + spd >= 480) begin
          m_act[k][i] = 1'b0;
          m_y[k][i]   = 0;
          if (m_score[k] < 65535) m_score[k]++;
        end else begin
          m_y[k][i] += spd;
        end
      end else if (m_cnt[k] == 0 && !sp) begin
        m_act[k][i] = 1'b1;
        m_y[k][i]   = 0;
        m_x[k][i]   = 178 + 106 * (int'(lf) % 3);
        m_cnt[k]    = spf(k);
        sp          = 1'b1;
      end
      dx = m_x[k][i] - m_px[k];
      if (dx < 0) dx = -dx;
      if (m_act[k][i] && m_y[k][i] + 84 > 380 && m_y[k][i] < 464 && dx < 72) hit = 1'b1;
    end
    if (m_cnt[k] > 0) m_cnt[k]--;
    m_lv[k] = (m_score[k] / 8 > 3) ? 3 : m_score[k] / 8;
    if (hit) m_st[k] = M_CRASH;
  endtask

  task automatic compare_all(input string ph);
    logic [63:0] ex, ey, ea;
    for (int k = 0; k < 2; k++) begin
      ex = '0; ey = '0; ea = '0;
      for (int i = 0; i < nopp(k); i++) begin
        ex[10*i +: 10] = 10'(m_x[k][i]);
        ey[9*i +: 9]   = 9'(m_y[k][i]);
        ea[i]          = m_act[k][i];
      end
      check_eq($sformatf("%s[%0d] player_x", ph, k), (k == 0) ? 64'(px0) : 64'(px1), 64'(m_px[k]));
      check_eq($sformatf("%s[%0d] opp_x", ph, k),    (k == 0) ? 64'(ox0) : 64'(ox1), ex);
      check_eq($sformatf("%s[%0d] opp_y", ph, k),    (k == 0) ? 64'(oy0) : 64'(oy1), ey);
      check_eq($sformatf("%s[%0d] opp_active", ph, k), (k == 0) ? 64'(oa0) : 64'(oa1), ea);
      check_eq($sformatf("%s[%0d] score", ph, k),    (k == 0) ? 64'(sc0) : 64'(sc1), 64'(m_score[k]));
      check_eq($sformatf("%s[%0d] level", ph, k),    (k == 0) ? 64'(lv0) : 64'(lv1), 64'(m_lv[k]));
      check_eq($sformatf("%s[%0d] crash", ph, k),    (k == 0) ? 64'(cr0) : 64'(cr1),
               64'(m_st[k] == M_CRASH));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear(0, M_IDLE);
    model_clear(1, M_IDLE);
    cur_lane = 1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++)
      if (m_st[k] != M_RUN) model_clear(k, M_RUN);
    cur_lane = 1;
  endtask

  // One frame: tick, optional extra tick mid-sweep, busy-length check, model compare.
  task automatic do_tick(input string ph, input bit extra);
    logic [15:0] l0;
    int bc[2];
    int exp_b;
    @(negedge clk);
    l0 = lref;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bc[0] = 0; bc[1] = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (bz0) bc[0]++;
      if (bz1) bc[1]++;
      if (extra) frame_tick = (c == 2);
    end
    frame_tick = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_b = (m_st[k] == M_RUN) ? nopp(k) + 2 : 0;
      check_eq($sformatf("%s[%0d] busy_cycles", ph, k), 64'(bc[k]), 64'(exp_b));
      model_tick(k, l0, control);
    end
    compare_all(ph);
  endtask

  // Closest not-yet-passed opponent in lane ln (below ylim), -1 if none.
  function automatic int threat(input int ln, input int ylim);
    int t = -1;
    for (int i = 0; i < 3; i++)
      if (m_act[0][i] && m_x[0][i] == 178 + 106 * ln && m_y[0][i] < ylim && m_y[0][i] > t)
        t = m_y[0][i];
    return t;
  endfunction

  task automatic steer(input bit seek);
    int tv, bv, tgt;
    if (seek) begin
      bv = threat(cur_lane, 296);
      for (int ln = 0; ln < 3; ln++) begin
        tv = threat(ln, 296);
        if (tv > bv) begin bv = tv; cur_lane = ln; end
      end
    end else if (threat(cur_lane, 464) > 150) begin
      bv = threat(cur_lane, 464);
      for (int ln = 0; ln < 3; ln++) begin
        tv = threat(ln, 464);
        if (tv < bv) begin bv = tv; cur_lane = ln; end
      end
    end
    tgt = (cur_lane == 0) ? 179 : (cur_lane == 1) ? 284 : 389;
    if (m_px[0] < tgt)      control = 2'b10;
    else if (m_px[0] > tgt) control = 2'b01;
    else                    control = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int frz_px, frz_sc;
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0; control = 2'b00;
    model_clear(0, M_IDLE);
    model_clear(1, M_IDLE);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compare_all("reset");
    check_eq("reset busy0", 64'(bz0), 64'd0);
    check_eq("reset busy1", 64'(bz1), 64'd0);

    // frame_tick in IDLE is ignored
    do_tick("idle_tick", 1'b0);

    pulse_start();
    compare_all("start");

    // first frame: spawn in slot 0, player centred
    do_tick("first", 1'b0);
    check_eq("first player_x", 64'(px0), 64'd284);

    control = 2'b10;
    for (int t = 0; t < 40; t++) do_tick("right", t[0]);
    check_eq("right saturate", 64'(px0), 64'd404);

    do_reset();
    pulse_start();
    control = 2'b01;
    for (int t = 0; t < 40; t++) do_tick("left", t[1]);
    check_eq("left saturate", 64'(px0), 64'd164);

    // long run dodging, random gaps, extra ticks during busy, stray starts
    do_reset();
    pulse_start();
    for (int t = 0; t < 700; t++) begin
      if (m_st[0] != M_RUN || m_score[0] >= 9) break;
      steer(1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 15) == 0) pulse_start();
      do_tick("dodge", ($urandom_range(0, 3) == 0));
    end

    // steer into an opponent's lane until a crash
    for (int t = 0; t < 400; t++) begin
      if (m_st[0] != M_RUN) break;
      steer(1'b1);
      do_tick("seek", 1'b0);
    end
    check_eq("crash rise", 64'(cr0), 64'd1);
    frz_px = m_px[0];
    frz_sc = m_score[0];
    for (int t = 0; t < 10; t++) begin
      control = 2'($urandom_range(1, 2));
      do_tick("frozen", 1'b0);
    end
    check_eq("frozen player_x", 64'(px0), 64'(frz_px));
    check_eq("frozen score", 64'(sc0), 64'(frz_sc));

    pulse_start();
    compare_all("restart");
    check_eq("restart score", 64'(sc0), 64'd0);

    for (int t = 0; t < 30; t++) begin
      control = 2'($urandom_range(0, 3));
      do_tick("random", ($urandom_range(0, 1) == 1));
    end

    // reset asserted mid-sweep returns outputs at once
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midreset busy0", 64'(bz0), 64'd0);
    check_eq("midreset busy1", 64'(bz1), 64'd0);
    check_eq("midreset player_x", 64'(px0), 64'd284);
    check_eq("midreset score", 64'(sc0), 64'd0);
    check_eq("midreset active0", 64'(oa0), 64'd0);
    check_eq("midreset active1", 64'(oa1), 64'd0);
    check_eq("midreset opp_y1", 64'(oy1), 64'd0);
    check_eq("midreset crash", 64'(cr0), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_clear(0, M_IDLE);
    model_clear(1, M_IDLE);
    @(negedge clk);
    compare_all("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
